// File: rtl/gray_to_binary_sync.sv
// Receive side of a Gray-coded pointer/counter crossing: synchronise, decode to binary, flag steps.
// Optional macro GRAY_ERR_CNT_EN adds a saturating 8-bit count of illegal transitions (err_cnt).
module gray_to_binary_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             changed,
  output logic             illegal
`ifdef GRAY_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;

  logic [WIDTH-1:0] bin_out_reg;
  logic [WIDTH-1:0] prev_gray_reg;
  logic [CNT_W-1:0] warm_cnt_reg;
  logic             changed_reg;
  logic             illegal_reg;

  // Synchroniser runs every cycle regardless of en so the chain never holds stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign sync_gray = sync_reg[SYNC_STAGES-1];

  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = sync_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ sync_gray[i];
    end
  end

  // More than one differing bit <=> clearing the lowest set bit leaves something behind.
  assign gray_diff = sync_gray ^ prev_gray_reg;
  assign multi_bit = (gray_diff & (gray_diff - 1'b1)) != '0;

  assign bin_valid = (warm_cnt_reg == WARM_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out_reg   <= '0;
      prev_gray_reg <= '0;
      warm_cnt_reg  <= '0;
      changed_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (en) begin
      bin_out_reg   <= dec_bin;
      prev_gray_reg <= sync_gray;
      if (warm_cnt_reg != WARM_MAX) begin
        warm_cnt_reg <= warm_cnt_reg + 1'b1;
      end
      changed_reg   <= bin_valid && (dec_bin != bin_out_reg);
      illegal_reg   <= bin_valid && multi_bit;
    end else begin
      changed_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
    end
  end

  assign bin_out = bin_out_reg;
  assign changed = changed_reg;
  assign illegal = illegal_reg;

`ifdef GRAY_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Advances on the same edge that raises illegal, so both are visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= 8'd0;
    end else if (en && bin_valid && multi_bit && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_gray_to_binary_sync.sv
// Scoreboard bench for gray_to_binary_sync: driver pushes per-edge expectations from a
// sample-history reference model, a negedge monitor pops and compares.
module tb_gray_to_binary_sync;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         changed;
  logic         illegal;
`ifdef GRAY_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  gray_to_binary_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .gray_in(gray_in),
    .en(en),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .changed(changed),
    .illegal(illegal)
`ifdef GRAY_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic         valid;
    logic         chg;
    logic         ill;
    int           err;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_x;
  int           checks = 0;
  int           errors = 0;

  // Reference model: history of sampled inputs plus the last decoded result.
  logic [W-1:0] pipe[$];
  logic [W-1:0] m_bin;
  logic [W-1:0] m_prev;
  int           m_edges;
  int           m_err;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    logic [W-1:0] x;
    b = '0;
    x = g;
    while (x != '0) begin
      b = b ^ x;
      x = x >> 1;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back('0);
    m_bin = '0;
    m_prev = '0;
    m_edges = 0;
    m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [W-1:0] g, input logic e);
    exp_t         x;
    logic [W-1:0] sg;
    logic [W-1:0] d;
    bit           was_valid;
    sg = pipe.pop_front();
    pipe.push_back(g);
    was_valid = (m_edges >= S + 1);
    x.chg = 1'b0;
    x.ill = 1'b0;
    if (e) begin
      d = g2b(sg);
      x.chg = was_valid && (d != m_bin);
      x.ill = was_valid && ($countones(sg ^ m_prev) > 1);
      m_bin = d;
      m_prev = sg;
      m_edges++;
      if (x.ill && m_err < 255) m_err++;
    end
    x.bin = m_bin;
    x.valid = (m_edges >= S + 1);
    x.err = m_err;
    exp_q.push_back(x);
  endtask

  // One cycle: drive just after negedge, expectation covers the coming posedge.
  task automatic cycle(input logic [W-1:0] g, input logic e);
    gray_in = g;
    en = e;
    model_edge(g, e);
    @(negedge clk);
    #2;
  endtask

  task automatic hold(input logic [W-1:0] g, input logic e, input int n);
    $display("TXN t=%0t gray=%b en=%0d cycles=%0d", $time, g, e, n);
    for (int i = 0; i < n; i++) cycle(g, e);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_bin_out"}, 32'(bin_out), 32'd0);
    chk({tag, "_bin_valid"}, 32'(bin_valid), 32'd0);
    chk({tag, "_changed"}, 32'(changed), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
`ifdef GRAY_ERR_CNT_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at t=%0t: got no expectation, required one per edge", $time);
      end else begin
        mon_x = exp_q.pop_front();
        chk("bin_out", 32'(bin_out), 32'(mon_x.bin));
        chk("bin_valid", 32'(bin_valid), 32'(mon_x.valid));
        chk("changed", 32'(changed), 32'(mon_x.chg));
        chk("illegal", 32'(illegal), 32'(mon_x.ill));
`ifdef GRAY_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(mon_x.err));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at t=%0t: got no finish, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           cur_b;
    int           r;
    logic [W-1:0] g;
    logic         e;

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk_zero_outputs("in_reset");
    rst = 1'b0;

    // Warm-up with zero input, then single-bit steps 0..4.
    hold(4'b0000, 1'b1, 5);
    hold(4'b0001, 1'b1, 4);
    hold(4'b0011, 1'b1, 4);
    hold(4'b0010, 1'b1, 4);
    hold(4'b0110, 1'b1, 4);

    // Wrap-around 15 -> 0 after settling on 15.
    hold(4'b1000, 1'b1, 6);
    hold(4'b0000, 1'b1, 6);

    // Two-bit jump: changed and illegal together.
    hold(4'b0011, 1'b1, 6);

    // Enable gap: input moves while en is low, resolves on re-enable.
    hold(4'b0001, 1'b1, 6);
    hold(4'b0011, 1'b0, 5);
    hold(4'b0011, 1'b1, 4);
    hold(4'b0010, 1'b1, 4);
    hold(4'b0110, 1'b1, 5);

    // Asynchronous reset between clock edges with bin_out = 4.
    $display("TXN t=%0t async reset", $time);
    #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    hold(4'b0110, 1'b1, 5);

    // Randomised walk: mostly single steps, occasional jumps, en mostly high.
    cur_b = 4;
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) cur_b = (cur_b + 1) % (1 << W);
      else if (r < 7) cur_b = (cur_b + (1 << W) - 1) % (1 << W);
      else if (r < 8) cur_b = int'($urandom_range(0, (1 << W) - 1));
      g = W'(cur_b ^ (cur_b >> 1));
      e = ($urandom_range(0, 9) < 8);
      hold(g, e, int'($urandom_range(1, 5)));
    end
    hold(g, 1'b1, 4);

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
